// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive sequencer and its host / line side.
// rx_state exposes the receiver FSM encoding for observation.
interface uart_rx_ctrl_if;
   logic       rx_sample_pulse;
   logic       rxd;
   logic       data_bits_8;
   logic       parity_odd;
   logic       rx_read;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       framing_err;
   logic       parity_err;
   logic       overrun_err;
   logic       rx_busy;
   logic [2:0] rx_state;

   // rx_read is a one-cycle pulse. When it meets rx_data_valid=1, the
   // holding register and its flags are released on the same PCLK edge
   // (or reloaded, if a new character commits on that edge).
   modport master (
      output rx_sample_pulse, rxd, data_bits_8, parity_odd, rx_read,
      input  rx_data, rx_data_valid, framing_err, parity_err, overrun_err,
      input  rx_busy, rx_state
   );

   modport slave (
      input  rx_sample_pulse, rxd, data_bits_8, parity_odd, rx_read,
      output rx_data, rx_data_valid, framing_err, parity_err, overrun_err,
      output rx_busy, rx_state
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: 16x-oversampled start/data/stop capture into a holding register.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int OVS_LAST    = 15,
   parameter int START_MID   = 7
) (
   input  logic          PCLK,
   input  logic          PRESET,
   uart_rx_ctrl_if.slave bus
);

   localparam logic [3:0] L_OVS_LAST  = 4'(OVS_LAST);
   localparam logic [3:0] L_START_MID = 4'(START_MID);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic             r_rxd_s_d;
   logic [3:0]       r_ovs_cnt, w_ovs_nxt;
   logic [3:0]       r_bit_cnt, w_bit_nxt;
   logic [7:0]       r_shift, w_shift_nxt;
   logic             r_d8, w_d8_nxt;
   logic             w_rxd_s;
   logic             w_tick;
   logic             w_last_bit;
   logic             w_commit;
   logic             w_pe;
   logic [7:0]       r_rx_data;
   logic             r_valid, r_fe, r_pe, r_oe;

   assign w_rxd_s    = r_sync[SYNC_STAGES-1];
   assign w_tick     = bus.rx_sample_pulse;
   assign w_last_bit = (r_bit_cnt == (r_d8 ? 4'd7 : 4'd6));

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_sync    <= '1;
         r_rxd_s_d <= 1'b1;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], bus.rxd};
         r_rxd_s_d <= w_rxd_s;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic r_par_bit, w_par_nxt;
   logic r_odd, w_odd_nxt;
   // Data bits plus parity bit must XOR to 1 for odd parity, 0 for even.
   assign w_pe = ((^r_shift) ^ r_par_bit) != r_odd;
`else
   logic w_unused_parity_odd;
   assign w_unused_parity_odd = bus.parity_odd;
   assign w_pe = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_ovs_nxt   = r_ovs_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_shift_nxt = r_shift;
      w_d8_nxt    = r_d8;
`ifdef UART_RX_PARITY_EN
      w_par_nxt   = r_par_bit;
      w_odd_nxt   = r_odd;
`endif
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Start detection runs every PCLK, not just on ticks.
            if (r_rxd_s_d && !w_rxd_s) begin
               w_state_nxt = S_START;
               w_ovs_nxt   = '0;
            end
         end
         S_START: begin
            if (w_tick) begin
               if (r_ovs_cnt == L_START_MID) begin
                  w_ovs_nxt = '0;
                  if (!w_rxd_s) begin
                     w_state_nxt = S_DATA;
                     w_bit_nxt   = '0;
                     w_shift_nxt = '0;
                     w_d8_nxt    = bus.data_bits_8;
`ifdef UART_RX_PARITY_EN
                     w_odd_nxt   = bus.parity_odd;
`endif
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_ovs_nxt = r_ovs_cnt + 4'd1;
               end
            end
         end
         S_DATA: begin
            if (w_tick) begin
               if (r_ovs_cnt == L_OVS_LAST) begin
                  w_shift_nxt[r_bit_cnt[2:0]] = w_rxd_s;
                  w_bit_nxt = r_bit_cnt + 4'd1;
                  w_ovs_nxt = '0;
                  if (w_last_bit) begin
`ifdef UART_RX_PARITY_EN
                     w_state_nxt = S_PARITY;
`else
                     w_state_nxt = S_STOP;
`endif
                  end
               end else begin
                  w_ovs_nxt = r_ovs_cnt + 4'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_tick) begin
               if (r_ovs_cnt == L_OVS_LAST) begin
                  w_par_nxt   = w_rxd_s;
                  w_state_nxt = S_STOP;
                  w_ovs_nxt   = '0;
               end else begin
                  w_ovs_nxt = r_ovs_cnt + 4'd1;
               end
            end
         end
`endif
         S_STOP: begin
            if (w_tick) begin
               if (r_ovs_cnt == L_OVS_LAST) begin
                  w_commit    = 1'b1;
                  w_state_nxt = S_IDLE;
                  w_ovs_nxt   = '0;
               end else begin
                  w_ovs_nxt = r_ovs_cnt + 4'd1;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_ovs_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state   <= S_IDLE;
         r_ovs_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_d8      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit <= 1'b0;
         r_odd     <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_ovs_cnt <= w_ovs_nxt;
         r_bit_cnt <= w_bit_nxt;
         r_shift   <= w_shift_nxt;
         r_d8      <= w_d8_nxt;
`ifdef UART_RX_PARITY_EN
         r_par_bit <= w_par_nxt;
         r_odd     <= w_odd_nxt;
`endif
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_rx_data <= '0;
         r_valid   <= 1'b0;
         r_fe      <= 1'b0;
         r_pe      <= 1'b0;
         r_oe      <= 1'b0;
      end else if (w_commit) begin
         // A read on the commit edge frees the register for the new character.
         if (!r_valid || bus.rx_read) begin
            r_rx_data <= r_shift;
            r_valid   <= 1'b1;
            r_fe      <= ~w_rxd_s;
            r_pe      <= w_pe;
            r_oe      <= 1'b0;
         end else begin
            r_oe      <= 1'b1;
         end
      end else if (bus.rx_read && r_valid) begin
         r_valid <= 1'b0;
         r_fe    <= 1'b0;
         r_pe    <= 1'b0;
         r_oe    <= 1'b0;
      end
   end

   assign bus.rx_data       = r_rx_data;
   assign bus.rx_data_valid = r_valid;
   assign bus.framing_err   = r_fe;
   assign bus.parity_err    = r_pe;
   assign bus.overrun_err   = r_oe;
   assign bus.rx_busy       = (r_state != S_IDLE);
   assign bus.rx_state      = r_state;

endmodule
